// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: steps the selects through each enabled channel,
// dwells DWELL cycles on each, and captures the mux output into result.
module mux_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] mask,
  input  logic       mux_out,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       sample,
  output logic [3:0] result,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       mask_q, mask_d;
  logic [1:0]       sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             sample_q, sample_d;
  logic [3:0]       result_q, result_d;

  // Lowest enabled channel strictly above cur; found=0 when none remains.
  function automatic logic [2:0] next_ch(input logic [3:0] m, input int cur);
    logic       found;
    logic [1:0] ch;
    found = 1'b0;
    ch    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!found && i > cur && m[i]) begin
        found = 1'b1;
        ch    = 2'(i);
      end
    end
    return {found, ch};
  endfunction

  logic [2:0] first_sel;
  logic [2:0] step_sel;

  always_comb begin
    first_sel = next_ch(mask, -1);
    step_sel  = next_ch(mask_q, int'(sel_q));

    state_d  = state_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    sample_d = 1'b0;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        sel_d  = 2'd0;
        busy_d = 1'b0;
        cnt_d  = '0;
        if (start) begin
          result_d = 4'b0000;
          if (mask != 4'b0000) begin
            mask_d  = mask;
            sel_d   = first_sel[1:0];
            busy_d  = 1'b1;
            state_d = RUN;
          end else begin
            state_d = FIN;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          result_d[sel_q] = mux_out;
          sample_d        = 1'b1;
          cnt_d           = '0;
          if (step_sel[2]) begin
            sel_d = step_sel[1:0];
          end else begin
            sel_d   = 2'd0;
            busy_d  = 1'b0;
            state_d = FIN;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mask_q   <= 4'b0000;
      sel_q    <= 2'd0;
      busy_q   <= 1'b0;
      sample_q <= 1'b0;
      result_q <= 4'b0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      sample_q <= sample_d;
      result_q <= result_d;
    end
  end

  assign s0     = sel_q[0];
  assign s1     = sel_q[1];
  assign busy   = busy_q;
  assign sample = sample_q;
  assign result = result_q;
  assign done   = (state_q == FIN);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with a behavioural 4:1 mux and a capture scoreboard.
module tb_mux_scan_ctrl;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] mask = 4'b0000;
  logic [3:0] mux_in = 4'b0000;
  logic       mux_out;
  logic       s0, s1, busy, sample, done;
  logic [3:0] result;

  int checks = 0;
  int failures = 0;

  logic [1:0] ch_q[$];
  logic [3:0] res_q[$];

  always #5 clk = ~clk;

  assign mux_out = mux_in[{s1, s0}];

  mux_scan_ctrl #(.DWELL(DWELL), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mask(mask), .mux_out(mux_out),
    .s0(s0), .s1(s1), .busy(busy), .sample(sample), .result(result), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_outs"}, {26'd0, s1, s0, busy, sample, done, 1'b0}, 32'd0);
    chk({tag, "_result"}, {28'd0, result}, 32'd0);
  endtask

  // One scan: m/data stimulus; restart_at/rst_at are cycle offsets from the start edge (-1 = unused).
  task automatic scan(input logic [3:0] m, input logic [3:0] data,
                      input int restart_at, input int rst_at);
    logic [1:0] chans[4];
    int         k = 0;
    int         n = 0;
    int         cap_idx = 0;
    int         done_cnt = 0;
    int         extra = 0;
    int         limit;
    logic [1:0] prev_sel = 2'd0;
    logic [1:0] exp_ch;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        chans[k] = 2'(i);
        ch_q.push_back(2'(i));
        k++;
      end
    end
    res_q.push_back(m & data);
    limit = k * DWELL + 8;

    @(negedge clk);
    mask   = m;
    mux_in = data;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;

    while (n < limit) begin
      if (n == rst_at) begin
        chk_idle_zero("rst_abort");
        rst = 1'b0;
        for (int c = 0; c < 2 * DWELL; c++) begin
          @(negedge clk);
          chk("rst_no_done", {31'd0, done}, 32'd0);
          chk("rst_no_busy", {31'd0, busy}, 32'd0);
        end
        ch_q.delete();
        res_q.delete();
        return;
      end
      if (n == restart_at) begin
        start = 1'b1;
        mask  = 4'b0001;
      end
      if (n == restart_at + 1) start = 1'b0;

      if (n < k * DWELL) begin
        chk("sel", {30'd0, s1, s0}, {30'd0, chans[n / DWELL]});
        chk("busy_run", {31'd0, busy}, 32'd1);
      end else begin
        chk("sel_idle", {30'd0, s1, s0}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
      end

      if (sample) begin
        if (ch_q.size() == 0) begin
          chk("sample_extra", {31'd0, sample}, 32'd0);
        end else begin
          exp_ch = ch_q.pop_front();
          chk("sample_ch", {30'd0, prev_sel}, {30'd0, exp_ch});
          chk("sample_time", n, (cap_idx + 1) * DWELL);
          cap_idx++;
        end
      end

      if (done) begin
        done_cnt++;
        chk("done_count", done_cnt, 1);
        chk("done_time", n, k * DWELL);
        if (res_q.size() != 0) chk("result", {28'd0, result}, {28'd0, res_q.pop_front()});
        else chk("result_unexpected", {31'd0, done}, 32'd0);
      end

      if (done_cnt != 0) begin
        extra++;
        if (extra > 3) break;
      end
      if (n == rst_at - 1) rst = 1'b1;
      prev_sel = {s1, s0};
      @(negedge clk);
      n++;
    end

    chk("done_seen", done_cnt, 1);
    chk("captures", cap_idx, k);
    chk("sb_ch_empty", ch_q.size(), 0);
    chk("sb_res_empty", res_q.size(), 0);
    chk("result_hold", {28'd0, result}, {28'd0, m & data});
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    mask  = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk_idle_zero("reset");
    end
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk_idle_zero("post_reset");

    scan(4'b1111, 4'b1010, -1, -1);
    scan(4'b0101, 4'b1111, -1, -1);
    scan(4'b0000, 4'b1111, -1, -1);
    scan(4'b1001, 4'b0001, -1, -1);
    scan(4'b1111, 4'b0101, 6, -1);
    scan(4'b1111, 4'b1111, -1, 9);
    scan(4'b1111, 4'b0110, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
